// File: rtl/wb_openram_pkg.sv
// Shared types and constants for the banked OpenRAM Wishbone bridge.
// Latency: none; it holds declarations only.
// Backpressure: not applicable.
//
// Contents: FSM state enum, Wishbone data/select widths, and the bank-index
// width helper used by the decoder and the top level.
package wb_openram_pkg;

    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // A single bank still gets one index bit. The decoder requires that bit
    // to be 0 (bank < NUM_BANKS), so the decode matches a zero-width field.
    function automatic int bank_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wb_openram_banked_if.sv
// Wishbone B4 classic bus bundle between the management SoC and the RAM bridge.
// Latency: none; it carries wires only.
// Backpressure: the slave stalls the master by withholding ack/err.
//
// Signals, named from the slave's point of view:
//   wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i[3:0], wbs_adr_i[31:0], wbs_dat_i[31:0]
//   wbs_ack_o, wbs_err_o, wbs_dat_o[31:0]
interface wb_openram_banked_if;
    import wb_openram_pkg::*;

    logic               wbs_cyc_i;
    logic               wbs_stb_i;
    logic               wbs_we_i;
    logic [WB_SELW-1:0] wbs_sel_i;
    logic [31:0]        wbs_adr_i;
    logic [WB_DW-1:0]   wbs_dat_i;
    logic               wbs_ack_o;
    logic               wbs_err_o;
    logic [WB_DW-1:0]   wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_err_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_err_o, wbs_dat_o
    );

endinterface

// File: rtl/wb_openram_bank_dec.sv
// Combinational byte-address decoder producing {in_range, bank, word}.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
//
// Ports:
//   i_adr       byte address from the bus
//   o_in_range  address falls inside the RAM window and hits a populated bank
//   o_bank      bank index (the bits just above the word address)
//   o_word      word address within the bank
module wb_openram_bank_dec
    import wb_openram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          NUM_BANKS = 2,
    parameter int          BANK_AW   = 8,
    localparam int         BW        = bank_bits(NUM_BANKS)
) (
    input  logic [31:0]        i_adr,
    output logic               o_in_range,
    output logic [BW-1:0]      o_bank,
    output logic [BANK_AW-1:0] o_word
);

    localparam int          TAG_LSB = BANK_AW + 2 + BW;
    localparam logic [BW:0] NB      = (BW + 1)'(NUM_BANKS);

    logic w_tag_hit;
    logic w_unused_adr;

    assign o_word    = i_adr[BANK_AW+1:2];
    assign o_bank    = i_adr[TAG_LSB-1:BANK_AW+2];
    assign w_tag_hit = (i_adr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);

    // The bank-count test matters when NUM_BANKS is not a power of two.
    assign o_in_range = w_tag_hit && ({1'b0, o_bank} < NB);

    // Byte offset within the word plays no part in the decode.
    assign w_unused_adr = ^i_adr[1:0];

endmodule

// File: rtl/wb_openram_banked.sv
// Wishbone B4 classic slave bridging the management bus to NUM_BANKS OpenRAM macros.
// Latency: write ack 2 cycles after stb, read ack 2+READ_LATENCY, out-of-range 1.
// Backpressure: one access at a time; the master waits for ack/err, and dropping cyc aborts.
//
// Ports:
//   wb_clk_i, wb_rst_ni  clock and asynchronous active-low reset
//   wbs                  Wishbone slave bus (wb_openram_banked_if.slave)
//   ram_csb_o            per-bank chip select, active low, asserted only in ACCESS
//   ram_web_o            write enable, active low; ram_wmask_o/ram_addr_o/ram_din_o are shared
//   ram_dout_i           concatenated bank read data, with bank 0 in the LSBs
// Build option: define WB_OPENRAM_ERR_EN to terminate out-of-range accesses with
// wbs_err_o. Otherwise they are acked, reads return 0 and writes are dropped.
module wb_openram_banked
    import wb_openram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          NUM_BANKS    = 2,
    parameter int          BANK_AW      = 8,
    parameter int          READ_LATENCY = 1
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    wb_openram_banked_if.slave       wbs,
    output logic [NUM_BANKS-1:0]     ram_csb_o,
    output logic                     ram_web_o,
    output logic [WB_SELW-1:0]       ram_wmask_o,
    output logic [BANK_AW-1:0]       ram_addr_o,
    output logic [WB_DW-1:0]         ram_din_o,
    input  logic [NUM_BANKS*WB_DW-1:0] ram_dout_i
);

    localparam int BW = bank_bits(NUM_BANKS);

    // Decode of the live bus address
    logic               w_dec_in_range;
    logic [BW-1:0]      w_dec_bank;
    logic [BANK_AW-1:0] w_dec_word;

    wb_openram_bank_dec #(
        .BASE_ADDR (BASE_ADDR),
        .NUM_BANKS (NUM_BANKS),
        .BANK_AW   (BANK_AW)
    ) u_dec (
        .i_adr      (wbs.wbs_adr_i),
        .o_in_range (w_dec_in_range),
        .o_bank     (w_dec_bank),
        .o_word     (w_dec_word)
    );

    // State and registered outputs
    state_t               r_state;
    logic [1:0]           r_cnt;
    logic [BW-1:0]        r_bank;
    logic                 r_we;
    logic [NUM_BANKS-1:0] r_csb;
    logic                 r_web;
    logic [WB_SELW-1:0]   r_wmask;
    logic [BANK_AW-1:0]   r_addr;
    logic [WB_DW-1:0]     r_din;
    logic                 r_ack;
    logic                 r_err;
    logic [WB_DW-1:0]     r_dat;

    state_t               w_state_nxt;
    logic [1:0]           w_cnt_nxt;
    logic [BW-1:0]        w_bank_nxt;
    logic                 w_we_nxt;
    logic [NUM_BANKS-1:0] w_csb_nxt;
    logic                 w_web_nxt;
    logic [WB_SELW-1:0]   w_wmask_nxt;
    logic [BANK_AW-1:0]   w_addr_nxt;
    logic [WB_DW-1:0]     w_din_nxt;
    logic                 w_ack_nxt;
    logic                 w_err_nxt;
    logic [WB_DW-1:0]     w_dat_nxt;
    logic [WB_DW-1:0]     w_dout_sel;

    // Read-data mux over the bank captured at request time
    always_comb begin
        w_dout_sel = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (r_bank == BW'(b)) begin
                w_dout_sel = ram_dout_i[b*WB_DW +: WB_DW];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bank_nxt  = r_bank;
        w_we_nxt    = r_we;
        w_csb_nxt   = '1;       // chip selects stay low for the ACCESS cycle only
        w_web_nxt   = 1'b1;
        w_wmask_nxt = '0;
        w_addr_nxt  = r_addr;
        w_din_nxt   = r_din;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_dat_nxt   = r_dat;

        unique case (r_state)
            IDLE: begin
                if (wbs.wbs_cyc_i && wbs.wbs_stb_i) begin
                    w_we_nxt   = wbs.wbs_we_i;
                    w_bank_nxt = w_dec_bank;
                    if (w_dec_in_range) begin
                        for (int b = 0; b < NUM_BANKS; b++) begin
                            if (w_dec_bank == BW'(b)) begin
                                w_csb_nxt[b] = 1'b0;
                            end
                        end
                        w_web_nxt   = !wbs.wbs_we_i;
                        w_wmask_nxt = wbs.wbs_we_i ? wbs.wbs_sel_i : '0;
                        w_addr_nxt  = w_dec_word;
                        w_din_nxt   = wbs.wbs_dat_i;
                        w_state_nxt = ACCESS;
                    end else begin
                        w_state_nxt = RESP;
`ifdef WB_OPENRAM_ERR_EN
                        w_err_nxt   = 1'b1;
`else
                        w_ack_nxt   = 1'b1;
                        if (!wbs.wbs_we_i) begin
                            w_dat_nxt = '0;
                        end
`endif
                    end
                end
            end
            ACCESS: begin
                // The macro samples csb at the end of this cycle. An issued
                // write therefore completes even if the master aborts now.
                if (!wbs.wbs_cyc_i) begin
                    w_state_nxt = IDLE;
                end else if (r_we) begin
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt   = 2'(READ_LATENCY - 1);
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!wbs.wbs_cyc_i) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == 2'd0) begin
                    w_dat_nxt   = w_dout_sel;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bank  <= '0;
            r_we    <= 1'b0;
            r_csb   <= '1;
            r_web   <= 1'b1;
            r_wmask <= '0;
            r_addr  <= '0;
            r_din   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bank  <= w_bank_nxt;
            r_we    <= w_we_nxt;
            r_csb   <= w_csb_nxt;
            r_web   <= w_web_nxt;
            r_wmask <= w_wmask_nxt;
            r_addr  <= w_addr_nxt;
            r_din   <= w_din_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_dat   <= w_dat_nxt;
        end
    end

    assign ram_csb_o     = r_csb;
    assign ram_web_o     = r_web;
    assign ram_wmask_o   = r_wmask;
    assign ram_addr_o    = r_addr;
    assign ram_din_o     = r_din;
    assign wbs.wbs_ack_o = r_ack;
    // Without WB_OPENRAM_ERR_EN, r_err never leaves its reset value of 0.
    assign wbs.wbs_err_o = r_err;
    assign wbs.wbs_dat_o = r_dat;

endmodule

// File: tb/tb_wb_openram_banked.sv
// Testbench: four DUT instances with READ_LATENCY 1..4 run the same directed
// stimulus against behavioural OpenRAM macro models. Each instance's
// handshake is tracked independently.
module tb_wb_openram_banked;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0]  cyc, stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;

    logic [3:0]       ack_v, err_v, web_v;
    logic [3:0][31:0] rdat_v, din_v;
    logic [3:0][1:0]  csb_v;
    logic [3:0][3:0]  wmask_v;
    logic [3:0][7:0]  addr_v;

    int n_checks = 0;
    int n_pass   = 0;

    int          lat[4];
    logic [31:0] rd[4];
    logic        got_ack[4], got_err[4];
    logic [1:0]  csb_obs[4];
    logic [3:0]  wm_obs[4];
    int          lows[4];
    int          both[4];

    for (genvar k = 0; k < 4; k++) begin : g
        wb_openram_banked_if bus ();
        logic [1:0]  csb;
        logic        web;
        logic [3:0]  wmask;
        logic [7:0]  addr;
        logic [31:0] din;
        logic [63:0] dout;
        logic [31:0] mem  [2][256];
        logic [31:0] pipe [2][4];

        assign bus.wbs_cyc_i = cyc[k];
        assign bus.wbs_stb_i = stb[k];
        assign bus.wbs_we_i  = we;
        assign bus.wbs_sel_i = sel;
        assign bus.wbs_adr_i = adr;
        assign bus.wbs_dat_i = wdat;

        wb_openram_banked #(
            .BASE_ADDR    (BASE),
            .NUM_BANKS    (2),
            .BANK_AW      (8),
            .READ_LATENCY (k + 1)
        ) dut (
            .wb_clk_i    (clk),
            .wb_rst_ni   (rst_n),
            .wbs         (bus.slave),
            .ram_csb_o   (csb),
            .ram_web_o   (web),
            .ram_wmask_o (wmask),
            .ram_addr_o  (addr),
            .ram_din_o   (din),
            .ram_dout_i  (dout)
        );

        // Macro model: samples on the edge ending ACCESS. Read data appears
        // k+1 edges later and is a poison pattern at all other times.
        always @(posedge clk) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 3; i > 0; i--) pipe[b][i] <= pipe[b][i-1];
                pipe[b][0] <= 32'hBAD0_BAD0;
                if (!csb[b]) begin
                    if (!web) begin
                        for (int j = 0; j < 4; j++)
                            if (wmask[j]) mem[b][addr][8*j +: 8] <= din[8*j +: 8];
                    end else begin
                        pipe[b][0] <= mem[b][addr];
                    end
                end
            end
        end
        assign dout[31:0]  = pipe[0][k];
        assign dout[63:32] = pipe[1][k];

        assign ack_v[k]   = bus.wbs_ack_o;
        assign err_v[k]   = bus.wbs_err_o;
        assign rdat_v[k]  = bus.wbs_dat_o;
        assign csb_v[k]   = csb;
        assign web_v[k]   = web;
        assign wmask_v[k] = wmask;
        assign addr_v[k]  = addr;
        assign din_v[k]   = din;
    end

    // One bus transaction on all four instances. Each instance is released as
    // soon as it terminates, so none of them sees a second request.
    task automatic access(input logic w, input logic [3:0] s, input logic [31:0] a,
                          input logic [31:0] d);
        logic [3:0] done;
        int n;
        we = w; sel = s; adr = a; wdat = d; done = '0; n = 0;
        for (int k = 0; k < 4; k++) begin
            lat[k] = -1; got_ack[k] = 1'b0; got_err[k] = 1'b0; rd[k] = 'x;
            csb_obs[k] = 2'b11; wm_obs[k] = 4'hx; lows[k] = 0; both[k] = 0;
        end
        cyc = 4'hF; stb = 4'hF;
        while (done != 4'hF && n < 20) begin
            @(posedge clk); #1; n++;
            for (int k = 0; k < 4; k++) begin
                if (!done[k]) begin
                    if (csb_v[k] != 2'b11) begin
                        csb_obs[k] = csb_v[k]; wm_obs[k] = wmask_v[k]; lows[k]++;
                    end
                    if (ack_v[k] && err_v[k]) both[k]++;
                    if (ack_v[k] || err_v[k]) begin
                        done[k] = 1'b1; lat[k] = n;
                        got_ack[k] = ack_v[k]; got_err[k] = err_v[k]; rd[k] = rdat_v[k];
                        cyc[k] = 1'b0; stb[k] = 1'b0;
                    end
                end
            end
        end
        cyc = '0; stb = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cyc = '0; stb = '0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({csb_v[k], ack_v[k], err_v[k], web_v[k], wmask_v[k], addr_v[k], din_v[k], rdat_v[k]}
                !== {2'b11, 1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 32'h0, 32'h0})
                $display("FAIL reset_state inst%0d: got csb=%b ack=%b err=%b web=%b wm=%h addr=%h din=%h dat=%h, want csb=11 ack=0 err=0 web=1 wm=0 addr=0 din=0 dat=0",
                         k, csb_v[k], ack_v[k], err_v[k], web_v[k], wmask_v[k], addr_v[k], din_v[k], rdat_v[k]);
            else n_pass++;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_readback();
        logic [31:0] addrs[2];
        logic [31:0] vals[2];
        logic [1:0]  csbs[2];
        addrs = '{BASE + 32'h000, BASE + 32'h400};
        vals  = '{32'hDEAD_BEEF, 32'hCAFE_F00D};
        csbs  = '{2'b10, 2'b01};
        for (int i = 0; i < 2; i++) begin
            access(1'b1, 4'hF, addrs[i], vals[i]);
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (lat[k] !== 2 || !got_ack[k] || got_err[k])
                    $display("FAIL wr%0d_lat inst%0d: got lat=%0d ack=%b err=%b, want lat=2 ack=1 err=0", i, k, lat[k], got_ack[k], got_err[k]);
                else n_pass++;
                n_checks++;
                if (csb_obs[k] !== csbs[i] || lows[k] !== 1 || wm_obs[k] !== 4'hF)
                    $display("FAIL wr%0d_csb inst%0d: got csb=%b cycles=%0d wm=%h, want csb=%b cycles=1 wm=f", i, k, csb_obs[k], lows[k], wm_obs[k], csbs[i]);
                else n_pass++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            access(1'b0, 4'hF, addrs[i], 32'h0);
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (lat[k] !== k + 3 || rd[k] !== vals[i] || both[k] !== 0)
                    $display("FAIL rd%0d inst%0d: got lat=%0d data=%h both=%0d, want lat=%0d data=%h both=0", i, k, lat[k], rd[k], both[k], k + 3, vals[i]);
                else n_pass++;
                n_checks++;
                if (csb_obs[k] !== csbs[i] || lows[k] !== 1)
                    $display("FAIL rd%0d_csb inst%0d: got csb=%b cycles=%0d, want csb=%b cycles=1", i, k, csb_obs[k], lows[k], csbs[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_byte_mask();
        access(1'b1, 4'hF,    BASE + 32'h10, 32'h1122_3344);
        access(1'b1, 4'b0101, BASE + 32'h10, 32'hAABB_CCDD);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (wm_obs[k] !== 4'b0101 || lat[k] !== 2)
                $display("FAIL mask_wr inst%0d: got wm=%b lat=%0d, want wm=0101 lat=2", k, wm_obs[k], lat[k]);
            else n_pass++;
        end
        access(1'b0, 4'hF, BASE + 32'h10, 32'h0);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rd[k] !== 32'h11BB_33DD)
                $display("FAIL mask_rd inst%0d: got %h want 11bb33dd", k, rd[k]);
            else n_pass++;
        end
        // A zero byte select still issues the access and is acked, but writes nothing.
        access(1'b1, 4'h0, BASE + 32'h10, 32'hFFFF_FFFF);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (lat[k] !== 2 || !got_ack[k] || csb_obs[k] !== 2'b10 || wm_obs[k] !== 4'h0)
                $display("FAIL sel0_wr inst%0d: got lat=%0d ack=%b csb=%b wm=%h, want lat=2 ack=1 csb=10 wm=0", k, lat[k], got_ack[k], csb_obs[k], wm_obs[k]);
            else n_pass++;
        end
        access(1'b0, 4'hF, BASE + 32'h10, 32'h0);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rd[k] !== 32'h11BB_33DD)
                $display("FAIL sel0_rd inst%0d: got %h want 11bb33dd", k, rd[k]);
            else n_pass++;
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] oor[2];
        oor = '{BASE + 32'h800, 32'h3100_0000};
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 2; w++) begin
                access(w[0], 4'hF, oor[i], 32'h5555_AAAA);
                for (int k = 0; k < 4; k++) begin
                    n_checks++;
`ifdef WB_OPENRAM_ERR_EN
                    if (got_err[k] !== 1'b1 || got_ack[k] !== 1'b0 || lows[k] !== 0 || both[k] !== 0)
                        $display("FAIL oor%0d_we%0d inst%0d: got err=%b ack=%b csb_cycles=%0d, want err=1 ack=0 csb_cycles=0", i, w, k, got_err[k], got_ack[k], lows[k]);
                    else n_pass++;
`else
                    if (got_ack[k] !== 1'b1 || got_err[k] !== 1'b0 || lows[k] !== 0 || (w == 0 && rd[k] !== 32'h0))
                        $display("FAIL oor%0d_we%0d inst%0d: got ack=%b err=%b csb_cycles=%0d data=%h, want ack=1 err=0 csb_cycles=0 data=0", i, w, k, got_ack[k], got_err[k], lows[k], rd[k]);
                    else n_pass++;
`endif
                end
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] held;
        logic [3:0]  seen;
`ifdef WB_OPENRAM_ERR_EN
        held = 32'h11BB_33DD;
`else
        held = 32'h0;
`endif
        seen = '0;
        we = 1'b0; sel = 4'hF; adr = BASE; cyc = 4'hF; stb = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        cyc = '0; stb = '0;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | ack_v | err_v;
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (seen[k] !== 1'b0 || rdat_v[k] !== held)
                $display("FAIL abort inst%0d: got ack_seen=%b dat=%h, want ack_seen=0 dat=%h", k, seen[k], rdat_v[k], held);
            else n_pass++;
        end
        access(1'b0, 4'hF, BASE + 32'h400, 32'h0);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (lat[k] !== k + 3 || rd[k] !== 32'hCAFE_F00D)
                $display("FAIL abort_next inst%0d: got lat=%0d data=%h, want lat=%0d data=cafef00d", k, lat[k], rd[k], k + 3);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_read();
        access(1'b0, 4'hF, BASE + 32'h10, 32'h0);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rd[k] !== 32'h11BB_33DD)
                $display("FAIL pre_rst_rd inst%0d: got %h want 11bb33dd", k, rd[k]);
            else n_pass++;
        end
        we = 1'b0; sel = 4'hF; adr = BASE; cyc = 4'hF; stb = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0; cyc = '0; stb = '0;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (csb_v[k] !== 2'b11 || ack_v[k] !== 1'b0 || rdat_v[k] !== 32'h0)
                $display("FAIL rst_mid inst%0d: got csb=%b ack=%b dat=%h, want csb=11 ack=0 dat=0", k, csb_v[k], ack_v[k], rdat_v[k]);
            else n_pass++;
        end
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 4'hF, BASE + 32'h400, 32'h0);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (lat[k] !== k + 3 || rd[k] !== 32'hCAFE_F00D)
                $display("FAIL post_rst_rd inst%0d: got lat=%0d data=%h, want lat=%0d data=cafef00d", k, lat[k], rd[k], k + 3);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_write_readback();
        test_byte_mask();
        test_out_of_range();
        test_abort();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wb_openram_banked.md
Name: wb_openram_banked

Overview:
Wishbone B4 classic slave that bridges the Caravel management bus to NUM_BANKS OpenRAM single-port macros (csb/web/wmask/addr/din/dout style). It is the parametrised successor of the single-macro wb_openram wrapper, adding configurable bank count, bank depth, base address and macro read latency, plus byte-masked writes and out-of-range handling. It sits in user_project_wrapper between the wbs_* bus and the SRAM macro instances.

Parameters:
- BASE_ADDR, 32'h3000_0000, byte base address of the RAM window; must be aligned to the window size.
- NUM_BANKS, 2, number of macros (1..8); need not be a power of two.
- BANK_AW, 8, word-address width per bank (256 words).
- READ_LATENCY, 1, macro cycles from the csb-sampling edge to valid dout (1..4).

Ports:
- wb_clk_i  in  1  bus and macro clock
- wb_rst_ni  in  1  asynchronous active-low reset
- wbs_cyc_i  in  1  bus cycle
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_err_o  out  1  error termination (see Optional Feature)
- wbs_dat_o  out  32  read data
- ram_csb_o  out  NUM_BANKS  per-bank chip select, active low
- ram_web_o  out  1  write enable, active low, shared
- ram_wmask_o  out  4  byte write mask, shared
- ram_addr_o  out  BANK_AW  word address, shared
- ram_din_o  out  32  write data, shared
- ram_dout_i  in  NUM_BANKS*32  concatenated bank read data, bank 0 in LSBs

Behaviour:
- Reset, asynchronous, taking effect immediately: ram_csb_o all 1, ram_web_o=1, ram_wmask_o=0, ram_addr_o=0, ram_din_o=0, wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0, state=IDLE, latency counter=0.
- Decode:
  - word = adr[BANK_AW+1:2].
  - bank = next ceil(log2(NUM_BANKS)) bits above word.
  - In range when adr[31:BANK_AW+2+bank bits] matches BASE_ADDR and bank < NUM_BANKS.
  - adr[1:0] is ignored.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: when cyc&stb is high in cycle N, register the decode.
  - In range: drive the selected csb low plus addr/din/wmask (wmask = sel if we, else 0) and web=!we at edge N+1; go to ACCESS.
  - Out of range: go to RESP with the error flag set.
- ACCESS: exactly one cycle; the macro samples at edge N+2, where csb returns high.
  - Write: go to RESP. wbs_ack_o is high in cycle N+2, so write latency is 2.
  - Read: go to WAIT with counter=READ_LATENCY-1.
- WAIT: decrement the counter each cycle. At 0, capture the selected bank's dout into wbs_dat_o and enter RESP.
  - wbs_ack_o is high in cycle N+2+READ_LATENCY (read latency 3 at default).
- RESP: ack (or err) is high for exactly one cycle, then return to IDLE. The next request is accepted no earlier than the cycle after ack.
- Write with sel=0: the access is issued with wmask=0, memory is unchanged, and ack is still returned.
- cyc dropped during ACCESS/WAIT: abort to IDLE, assert no ack, and leave wbs_dat_o unchanged. A write already issued in ACCESS completes in the macro.
- ack and err are never high simultaneously. Only one csb bit is low at any time, and only in ACCESS.
- wbs_dat_o holds its last read value between reads.

Optional Feature:
- Macro WB_OPENRAM_ERR_EN.
- Defined: an out-of-range access asserts wbs_err_o for one cycle in RESP, with wbs_ack_o=0.
- Undefined: wbs_err_o is tied 0, and an out-of-range access gets wbs_ack_o. A read returns 32'h0000_0000; a write is dropped.
- In both cases no csb is asserted for out-of-range accesses.

Decomposition:
- Package wb_openram_pkg:
  - FSM state enum (IDLE, ACCESS, WAIT, RESP).
  - WB_DW=32 and WB_SELW=4 constants.
  - A function computing the bank-index width from NUM_BANKS.
- Sub-module wb_openram_bank_dec: purely combinational address to {in_range, bank, word} decoder, parametrised by BASE_ADDR, NUM_BANKS and BANK_AW.

Test Plan:
- Reset mid-read: assert wb_rst_ni low during WAIT -> all csb high and ack low within the same cycle; after release, a new read completes normally.
- Write then read-back across banks: write 32'hDEAD_BEEF to BASE+0x000 and 32'hCAFE_F00D to BASE+0x400 (bank 1, BANK_AW=8), then read both back.
  - Each write acks 2 cycles after stb.
  - Each read acks 3 cycles after stb and returns the written value.
  - ram_csb_o equals 2'b10 for bank 0 and 2'b01 for bank 1.
- Byte mask: write 32'h1122_3344 sel=4'hF, then 32'hAABB_CCDD sel=4'b0101, then read -> 32'h11BB_33DD.
- Latency sweep: rerun the read-back with READ_LATENCY=1..4 -> ack exactly 2+READ_LATENCY cycles after stb.
- Out of range: access BASE+0x800 with NUM_BANKS=2, and access 32'h3100_0000.
  - With WB_OPENRAM_ERR_EN: err for one cycle, no ack, no csb.
  - Without it: ack, read data 0, no csb.
- Abort: drop cyc during WAIT -> no ack and a return to IDLE; the next read returns correct data with nominal latency.
